game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level game controller for the VGA brick game.
- Sequences the ball/paddle/brick datapath through idle, serve, play, pause, miss, win and game-over phases.
- Paces ball motion from frame sync. Owns lives, score and level, and issues brick-reload and ball-reset commands.
- Sits between the screen timing block (VS), the push-buttons, and the ball/brick update logic; drives `finish` to the pixel colouring logic.

Parameters:
- LIVES, 3, lives loaded at game start (1..7).
- FRAMES_PER_STEP, 12, frame ticks between ball moves at level 0 (~200 ms at 60 Hz).
- MIN_FRAMES, 2, floor on frames per step.
- SERVE_FRAMES, 60, frame ticks spent in SERVE before play resumes.
- MAX_LEVEL, 3, level saturation value.
- DEBOUNCE_CYC, 500000, clk cycles a key must be stably low to count as a press.
- SCORE_W, 8, score width.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `vs`  in  1  vertical sync from screen block, active low, asynchronous to this logic.
- `key_n`  in  1  start/pause button, active low, unsynchronised.
- `brick_hit`  in  1  one-cycle pulse, ball destroyed a brick.
- `ball_lost`  in  1  one-cycle pulse, ball reached bottom edge.
- `bricks_left`  in  4  live brick count from brick state register.
- `move_en`  out  1  one-cycle pulse: advance ball one step.
- `ball_reset`  out  1  level high throughout SERVE: hold ball at serve position.
- `bricks_reload`  out  1  one-cycle pulse: set all brick states alive.
- `state`  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4, WIN=5.
- `lives`  out  3  remaining lives.
- `score`  out  SCORE_W  bricks destroyed.
- `level`  out  2  current level.
- `finish`  out  1  high in OVER.

Behaviour:
- **Reset** (`reset`=0, async): state=IDLE; lives=0, score=0, level=0; `move_en`=0, `bricks_reload`=0, `ball_reset`=0, `finish`=0; all counters and sync flops cleared, with the `key_n` and `vs` sync flops set to 1. Reset mid-game aborts immediately; no pulse is emitted on release.
- **Frame tick:** `vs` passes through a 2-flop synchroniser, then a falling-edge detect. `frame_tick` is a one-cycle pulse 3 clk after the `vs` fall.
- **Key press:**
  - `key_n` passes through a 2-flop synchroniser.
  - A debounce counter counts while the synced key is low and clears when it is high.
  - `press` is a one-cycle pulse when the count reaches DEBOUNCE_CYC-1. Exactly one pulse per hold; no repeat until the key has been high for at least 1 cycle.
- **step_frames** = max(FRAMES_PER_STEP − 2·level, MIN_FRAMES), evaluated combinationally from `level`.
- **IDLE:**
  - On `press`: lives=LIVES, score=0, level=0; `bricks_reload` pulses once.
  - Next state SERVE.
- **SERVE:**
  - `ball_reset`=1.
  - Frame counter increments on `frame_tick`. When it reaches SERVE_FRAMES: counter cleared, state goes to PLAY.
  - `press` is ignored.
- **PLAY:**
  - Frame counter increments on `frame_tick`. On the tick where count+1 == step_frames, `move_en` pulses in the same cycle and the counter clears.
  - `brick_hit`: score+1, saturating at 2^SCORE_W−1.
  - Priority, high to low, evaluated each cycle:
    1. `bricks_left`==0 → WIN.
    2. `ball_lost` → lives−1. If lives was 1, go to OVER (lives=0); else go to SERVE.
    3. `press` → PAUSE.
  - `brick_hit` in the same cycle as any of these is still scored.
- **PAUSE:**
  - Frame counter frozen; no `move_en`.
  - `brick_hit`/`ball_lost` ignored.
  - `press` → PLAY, counter retained.
- **WIN:**
  - `press` → level = min(level+1, MAX_LEVEL); `bricks_reload` pulses; score and lives retained.
  - Next state SERVE.
- **OVER:** `finish`=1. `press` → IDLE; score, lives and level hold until the next start.
- Frame counter is cleared on every entry to SERVE or PLAY from any state except PAUSE.
- `move_en` is never asserted outside PLAY.

Test Plan:
- **Start:** reset, hold `key_n` low DEBOUNCE_CYC cycles → one `bricks_reload` pulse; state=SERVE; lives=3, score=0. After 60 `vs` falls → state=PLAY.
- **Pacing:** in PLAY with level=0, apply 36 `vs` falls → exactly 3 `move_en` pulses, each 3 clk after the 12th/24th/36th `vs` fall.
- **Scoring:** 255 `brick_hit` pulses → score=255. A further pulse → score stays 255.
- **Lives:** three `ball_lost` pulses, each after re-entering PLAY → lives 2 → SERVE, 1 → SERVE, 0 → OVER; `finish`=1. Then `press` → IDLE.
- **Simultaneous events:** `bricks_left`=0, `ball_lost` and `brick_hit` in the same cycle → state=WIN, lives unchanged, score+1. Then `press` → level=1 and `bricks_reload` pulse; in PLAY, step_frames=10. At level=3, a WIN press keeps level=3 (step_frames=6).
- **Pause/reset:** `press` in PLAY after 5 ticks → PAUSE; 20 `vs` falls give no `move_en`; `press` → PLAY; `move_en` arrives after 7 more ticks. Assert `reset`=0 mid-PLAY → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: brick-game phase FSM; paces ball moves from vsync, debounces the start/pause key, owns lives/score/level
module game_sequencer #(
  parameter int LIVES = 3,
  parameter int FRAMES_PER_STEP = 12,
  parameter int MIN_FRAMES = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int MAX_LEVEL = 3,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vs,
  input  logic               key_n,
  input  logic               brick_hit,
  input  logic               ball_lost,
  input  logic [3:0]         bricks_left,
  output logic               move_en,
  output logic               ball_reset,
  output logic               bricks_reload,
  output logic [2:0]         state,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         level,
  output logic               finish
);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, PAUSE = 3'd3, OVER = 3'd4, WIN = 3'd5} state_t;
  localparam int FMAX = FRAMES_PER_STEP > SERVE_FRAMES ? FRAMES_PER_STEP : SERVE_FRAMES;
  localparam int FW = $clog2(FMAX + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  state_t st;
  logic v1, v2, v3, k1, k2, tick, press;
  logic [DW-1:0] dcnt;
  logic [FW-1:0] fcnt, fcnt_inc, step_frames;
  assign state = st;
  assign tick = v3 & ~v2;
  assign press = ~k2 & (dcnt == DW'(DEBOUNCE_CYC - 1));
  assign fcnt_inc = fcnt + FW'(1);
  assign step_frames = (FRAMES_PER_STEP >= MIN_FRAMES + 2 * int'(level)) ? FW'(FRAMES_PER_STEP - 2 * int'(level)) : FW'(MIN_FRAMES);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {v1, v2, v3, k1, k2} <= '1;
      dcnt <= '0;
    end else begin
      {v3, v2, v1} <= {v2, v1, vs};
      {k2, k1} <= {k1, key_n};
      dcnt <= k2 ? '0 : dcnt + DW'(dcnt != DW'(DEBOUNCE_CYC));
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      lives <= '0;
      score <= '0;
      level <= '0;
      fcnt <= '0;
      move_en <= 1'b0;
      bricks_reload <= 1'b0;
      ball_reset <= 1'b0;
      finish <= 1'b0;
    end else begin
      move_en <= 1'b0;
      bricks_reload <= 1'b0;
      case (st)
        IDLE: if (press) begin
          lives <= 3'(LIVES);
          score <= '0;
          level <= '0;
          fcnt <= '0;
          bricks_reload <= 1'b1;
          ball_reset <= 1'b1;
          st <= SERVE;
        end
        SERVE: if (tick) begin
          if (fcnt_inc == FW'(SERVE_FRAMES)) begin
            fcnt <= '0;
            ball_reset <= 1'b0;
            st <= PLAY;
          end else fcnt <= fcnt_inc;
        end
        PLAY: begin
          if (brick_hit && score != '1) score <= score + SCORE_W'(1);
          if (bricks_left == 4'd0) st <= WIN;
          else if (ball_lost) begin
            lives <= lives - 3'd1;
            fcnt <= '0;
            if (lives == 3'd1) begin
              finish <= 1'b1;
              st <= OVER;
            end else begin
              ball_reset <= 1'b1;
              st <= SERVE;
            end
          end else if (press) st <= PAUSE;
          else if (tick) begin
            if (fcnt_inc == step_frames) begin
              fcnt <= '0;
              move_en <= 1'b1;
            end else fcnt <= fcnt_inc;
          end
        end
        PAUSE: if (press) st <= PLAY;
        WIN: if (press) begin
          level <= level != 2'(MAX_LEVEL) ? level + 2'd1 : level;
          fcnt <= '0;
          bricks_reload <= 1'b1;
          ball_reset <= 1'b1;
          st <= SERVE;
        end
        OVER: if (press) begin
          finish <= 1'b0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed checks of game_sequencer start, pacing, pause, scoring, lives, win/level and reset
module tb_game_sequencer;
  localparam int D = 8;
  localparam int SERVE = 60;
  logic clk = 0, reset = 1, vs = 1, key_n = 1, brick_hit = 0, ball_lost = 0;
  logic [3:0] bricks_left = 4'd5;
  logic move_en, ball_reset, bricks_reload, finish;
  logic [2:0] state, lives;
  logic [7:0] score;
  logic [1:0] level;
  int n_cmp = 0, n_bad = 0, reload_cnt = 0, move_cnt = 0;
  game_sequencer #(.DEBOUNCE_CYC(D)) dut (
    .clk(clk), .reset(reset), .vs(vs), .key_n(key_n), .brick_hit(brick_hit), .ball_lost(ball_lost),
    .bricks_left(bricks_left), .move_en(move_en), .ball_reset(ball_reset), .bricks_reload(bricks_reload),
    .state(state), .lives(lives), .score(score), .level(level), .finish(finish)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bricks_reload) reload_cnt++;
    if (move_en) move_cnt++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task frame(output logic me);
    @(negedge clk) vs = 0;
    repeat (3) @(negedge clk);
    me = move_en;
    vs = 1;
    repeat (3) @(negedge clk);
  endtask
  task press_key;
    @(negedge clk) key_n = 0;
    repeat (D + 4) @(negedge clk);
    key_n = 1;
    repeat (3) @(negedge clk);
  endtask
  task serve;
    logic me;
    repeat (SERVE) frame(me);
  endtask
  task hit;
    @(negedge clk) brick_hit = 1;
    @(negedge clk) brick_hit = 0;
  endtask
  task lose;
    @(negedge clk) ball_lost = 1;
    @(negedge clk) ball_lost = 0;
  endtask
  task win;
    @(negedge clk) bricks_left = 0;
    @(negedge clk) bricks_left = 5;
  endtask
  task test_reset;
    #1 reset = 0;
    @(negedge clk);
    n_cmp++; if ({state, lives, score, level, move_en, ball_reset, bricks_reload, finish} !== 20'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", {state, lives, score, level, move_en, ball_reset, bricks_reload, finish}); end
    @(negedge clk) reset = 1;
    repeat (3) @(negedge clk);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_idle: state got %0d want 0", state); end
  endtask
  task test_start;
    int r, m;
    logic me;
    r = reload_cnt;
    press_key;
    n_cmp++; if (reload_cnt - r !== 1) begin n_bad++; $display("FAIL start_reload: pulses got %0d want 1", reload_cnt - r); end
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL start_state: got %0d want 1", state); end
    n_cmp++; if (lives !== 3'd3) begin n_bad++; $display("FAIL start_lives: got %0d want 3", lives); end
    n_cmp++; if (score !== 8'd0) begin n_bad++; $display("FAIL start_score: got %0d want 0", score); end
    n_cmp++; if (ball_reset !== 1'b1) begin n_bad++; $display("FAIL start_ball_reset: got %0d want 1", ball_reset); end
    m = move_cnt;
    repeat (SERVE - 1) frame(me);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL serve_59: state got %0d want 1", state); end
    frame(me);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL serve_60: state got %0d want 2", state); end
    n_cmp++; if (ball_reset !== 1'b0) begin n_bad++; $display("FAIL serve_ball_reset_drop: got %0d want 0", ball_reset); end
    n_cmp++; if (move_cnt !== m) begin n_bad++; $display("FAIL serve_no_move: pulses got %0d want 0", move_cnt - m); end
  endtask
  task test_pacing;
    int m;
    logic me;
    m = move_cnt;
    for (int i = 1; i <= 36; i++) begin
      frame(me);
      n_cmp++; if (me !== (i % 12 == 0)) begin n_bad++; $display("FAIL pacing_frame%0d: move_en got %0d want %0d", i, me, i % 12 == 0); end
    end
    n_cmp++; if (move_cnt - m !== 3) begin n_bad++; $display("FAIL pacing_count: pulses got %0d want 3", move_cnt - m); end
  endtask
  task test_pause;
    int m;
    logic me;
    repeat (5) frame(me);
    press_key;
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL pause_enter: state got %0d want 3", state); end
    hit;
    n_cmp++; if (score !== 8'd0) begin n_bad++; $display("FAIL pause_hit_ignored: score got %0d want 0", score); end
    m = move_cnt;
    repeat (20) frame(me);
    n_cmp++; if (move_cnt !== m) begin n_bad++; $display("FAIL pause_no_move: pulses got %0d want 0", move_cnt - m); end
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL pause_hold: state got %0d want 3", state); end
    press_key;
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL pause_resume: state got %0d want 2", state); end
    for (int i = 1; i <= 7; i++) begin
      frame(me);
      n_cmp++; if (me !== (i == 7)) begin n_bad++; $display("FAIL resume_frame%0d: move_en got %0d want %0d", i, me, i == 7); end
    end
  endtask
  task test_scoring;
    repeat (255) hit;
    n_cmp++; if (score !== 8'd255) begin n_bad++; $display("FAIL score_255: got %0d want 255", score); end
    hit;
    n_cmp++; if (score !== 8'd255) begin n_bad++; $display("FAIL score_saturate: got %0d want 255", score); end
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL score_state: got %0d want 2", state); end
  endtask
  task test_lives;
    for (int k = 0; k < 3; k++) begin
      lose;
      n_cmp++; if (lives !== 3'(2 - k)) begin n_bad++; $display("FAIL lives_after_loss%0d: got %0d want %0d", k, lives, 2 - k); end
      n_cmp++; if (state !== (k == 2 ? 3'd4 : 3'd1)) begin n_bad++; $display("FAIL state_after_loss%0d: got %0d want %0d", k, state, k == 2 ? 4 : 1); end
      if (k < 2) serve;
    end
    n_cmp++; if (finish !== 1'b1) begin n_bad++; $display("FAIL over_finish: got %0d want 1", finish); end
    press_key;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL over_to_idle: state got %0d want 0", state); end
    n_cmp++; if (finish !== 1'b0) begin n_bad++; $display("FAIL idle_finish: got %0d want 0", finish); end
    n_cmp++; if (score !== 8'd255) begin n_bad++; $display("FAIL idle_score_hold: got %0d want 255", score); end
  endtask
  task test_simultaneous;
    int r;
    logic me;
    press_key;
    n_cmp++; if ({lives, score, level} !== {3'd3, 8'd0, 2'd0}) begin n_bad++; $display("FAIL restart_regs: lives %0d score %0d level %0d want 3 0 0", lives, score, level); end
    serve;
    @(negedge clk) begin bricks_left = 0; ball_lost = 1; brick_hit = 1; end
    @(negedge clk) begin bricks_left = 5; ball_lost = 0; brick_hit = 0; end
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL simul_state: got %0d want 5", state); end
    n_cmp++; if (lives !== 3'd3) begin n_bad++; $display("FAIL simul_lives: got %0d want 3", lives); end
    n_cmp++; if (score !== 8'd1) begin n_bad++; $display("FAIL simul_score: got %0d want 1", score); end
    r = reload_cnt;
    press_key;
    n_cmp++; if (level !== 2'd1) begin n_bad++; $display("FAIL win_level1: got %0d want 1", level); end
    n_cmp++; if (reload_cnt - r !== 1) begin n_bad++; $display("FAIL win_reload: pulses got %0d want 1", reload_cnt - r); end
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL win_to_serve: state got %0d want 1", state); end
    serve;
    for (int i = 1; i <= 10; i++) begin
      frame(me);
      n_cmp++; if (me !== (i == 10)) begin n_bad++; $display("FAIL level1_frame%0d: move_en got %0d want %0d", i, me, i == 10); end
    end
    for (int lv = 2; lv <= 4; lv++) begin
      win;
      press_key;
      n_cmp++; if (level !== 2'(lv > 3 ? 3 : lv)) begin n_bad++; $display("FAIL win_level_step%0d: got %0d want %0d", lv, level, lv > 3 ? 3 : lv); end
      serve;
    end
    for (int i = 1; i <= 6; i++) begin
      frame(me);
      n_cmp++; if (me !== (i == 6)) begin n_bad++; $display("FAIL level3_frame%0d: move_en got %0d want %0d", i, me, i == 6); end
    end
  endtask
  task test_reset_mid;
    int r;
    logic me;
    frame(me);
    @(negedge clk) reset = 0;
    #1;
    n_cmp++; if ({state, lives, score, level, move_en, ball_reset, bricks_reload, finish} !== 20'd0) begin n_bad++; $display("FAIL midplay_reset: got %h want 0", {state, lives, score, level, move_en, ball_reset, bricks_reload, finish}); end
    @(negedge clk) reset = 1;
    r = reload_cnt;
    repeat (5) @(negedge clk);
    n_cmp++; if (state !== 3'd0 || reload_cnt !== r) begin n_bad++; $display("FAIL reset_release: state %0d reloads %0d want 0 0", state, reload_cnt - r); end
  endtask
  initial begin
    test_reset;
    test_start;
    test_pacing;
    test_pause;
    test_scoring;
    test_lives;
    test_simultaneous;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
